// File: rtl/delay_sched_pkg.sv
// Shared types and limits for the delay-sharing scheduler.
// Stage records are sized for the largest supported configuration; instances
// zero-extend into them and truncate out of them, so unused upper bits are
// constant and drop out in synthesis.
package delay_sched_pkg;

    localparam int unsigned DSCHED_MAX_REQ   = 16;
    localparam int unsigned DSCHED_MAX_DEPTH = 64;
    localparam int unsigned DSCHED_MAX_WIDTH = 64;
    localparam int unsigned DSCHED_ID_W      = $clog2(DSCHED_MAX_REQ);

    // One pipeline stage: valid flag, originating requester and payload
    typedef struct packed {
        logic                        valid;
        logic [DSCHED_ID_W-1:0]      id;
        logic [DSCHED_MAX_WIDTH-1:0] data;
    } dsched_stage_t;

endpackage

// File: rtl/delay_share_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from the pointer,
// pointer moves past the winner when the caller reports a transfer.
// Ports:
//   i_clk, i_rst  clock, async active-high reset (pointer -> 0)
//   i_req         request vector
//   i_advance     a grant was consumed this cycle
//   o_grant       one-hot grant (zero when no request)
//   o_grant_idx   index of the granted requester
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic                       i_advance,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_idx
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW-1:0] cand;
    logic           found;

    // Pointer register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Search from the pointer with wrap; first requester found wins
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        found       = 1'b0;
        cand        = '0;
        ptr_d       = ptr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDW'((32'(ptr_q) + i) % NUM_REQ);
            if (!found && i_req[cand]) begin
                found         = 1'b1;
                o_grant[cand] = 1'b1;
                o_grant_idx   = cand;
            end
        end
        if (i_advance) begin
            ptr_d = (o_grant_idx == IDW'(NUM_REQ - 1)) ? '0 : o_grant_idx + IDW'(1);
        end
    end

endmodule

// File: rtl/delay_share_scheduler.sv
// Shares one programmable-latency delay pipeline among NUM_REQ requesters.
// Ports:
//   i_clk, i_rst              clock, async active-high reset
//   i_req_valid/i_req_data    per-requester word (slice r at r*WIDTH)
//   o_req_ready               one-hot grant, combinational
//   i_flush                   drop every in-flight word, block new grants
//   i_cfg_we/i_cfg_delay      delay write, applied only when idle and in range
//   o_cfg_delay               current delay
//   o_busy                    some word still inside the active stages (comb)
//   o_valid/o_data/o_id       delayed word and its requester
module delay_share_scheduler
    import delay_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned DEFAULT_DELAY = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic                       i_flush,
    input  logic                       i_cfg_we,
    input  logic [$clog2(DEPTH+1)-1:0] i_cfg_delay,
    output logic [$clog2(DEPTH+1)-1:0] o_cfg_delay,
    output logic                       o_busy,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(NUM_REQ)-1:0] o_id
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned CDW = $clog2(DEPTH + 1);

    logic [NUM_REQ-1:0] arb_req;
    logic [IDW-1:0]     grant_idx;
    logic               transfer;
    logic [WIDTH-1:0]   word;
    logic               cfg_ok;
    logic [CDW-1:0]     cfg_d;
    dsched_stage_t      stage_q [DEPTH];
    dsched_stage_t      stage_d [DEPTH];
    dsched_stage_t      tap;

    // Flush masks requests so nothing is granted and the pointer holds
    assign arb_req  = i_flush ? '0 : i_req_valid;
    assign transfer = |o_req_ready;
    assign word     = i_req_data[32'(grant_idx) * WIDTH +: WIDTH];

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (arb_req),
        .i_advance   (transfer),
        .o_grant     (o_req_ready),
        .o_grant_idx (grant_idx)
    );

    // Busy: any valid word in the stages covered by the current delay
    always_comb begin
        o_busy = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (CDW'(k) < o_cfg_delay && stage_q[k].valid) begin
                o_busy = 1'b1;
            end
        end
    end

    // Config acceptance, pipeline shift and tap selection
    always_comb begin
        cfg_ok = i_cfg_we && !o_busy && !i_flush &&
                 (i_cfg_delay != '0) && (i_cfg_delay <= CDW'(DEPTH));
        cfg_d  = cfg_ok ? i_cfg_delay : o_cfg_delay;

        stage_d[0].valid = transfer && !i_flush;
        stage_d[0].id    = DSCHED_ID_W'(grant_idx);
        stage_d[0].data  = DSCHED_MAX_WIDTH'(word);
        for (int unsigned k = 1; k < DEPTH; k++) begin
            stage_d[k]       = stage_q[k-1];
            // Stages beyond the active delay never hold a live word
            stage_d[k].valid = stage_q[k-1].valid && !i_flush && (CDW'(k) < cfg_d);
        end

        // The output register mirrors stage cfg_d-1, so it is loaded from that stage's next value
        tap = stage_d[0];
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (cfg_d == CDW'(k + 1)) begin
                tap = stage_d[k];
            end
        end
    end

    // Pipeline, config and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            o_cfg_delay <= CDW'(DEFAULT_DELAY);
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_id        <= '0;
        end else begin
            stage_q     <= stage_d;
            o_cfg_delay <= cfg_d;
            o_valid     <= tap.valid;
            if (tap.valid) begin
                o_data <= WIDTH'(tap.data);
                o_id   <= IDW'(tap.id);
            end
        end
    end

endmodule

// File: tb/tb_delay_share_scheduler.sv
// Randomized bench for delay_share_scheduler with a queue-based reference model:
// each accepted word is recorded with the cycle it must appear on the output.
module tb_delay_share_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        flush = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_delay = '0;
    logic [3:0]  cur_delay;
    logic        busy;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;

    always #5 clk = ~clk;

    delay_share_scheduler #(
        .NUM_REQ(4), .WIDTH(8), .DEPTH(8), .DEFAULT_DELAY(2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .i_flush     (flush),
        .i_cfg_we    (cfg_we),
        .i_cfg_delay (cfg_delay),
        .o_cfg_delay (cur_delay),
        .o_busy      (busy),
        .o_valid     (out_valid),
        .o_data      (out_data),
        .o_id        (out_id)
    );

    typedef struct {
        int due;
        int id;
        int data;
    } word_t;

    word_t q[$];
    int    ptr      = 0;
    int    delay    = 2;
    int    cyc      = 0;
    int    exp_data = 0;
    int    exp_id   = 0;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive, compare against the model, advance the model at the edge
    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic fl,
                        input logic we, input logic [3:0] cd);
        int         g;
        bit         mbusy;
        bit         exp_v;
        logic [3:0] exp_rdy;
        req_valid = v;
        req_data  = d;
        flush     = fl;
        cfg_we    = we;
        cfg_delay = cd;
        #1;
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        mbusy = (q.size() > 0);
        exp_v = mbusy && (q[0].due == cyc);
        if (exp_v) begin
            exp_data = q[0].data;
            exp_id   = q[0].id;
        end
        g = -1;
        if (!fl) begin
            for (int i = 0; i < 4; i++) begin
                int c;
                c = (ptr + i) % 4;
                if (g < 0 && v[c]) g = c;
            end
        end
        exp_rdy = (g < 0) ? 4'b0000 : 4'(1 << g);
        check("ready", 32'(req_ready), 32'(exp_rdy));
        check("busy",  32'(busy),      32'(mbusy));
        check("valid", 32'(out_valid), 32'(exp_v));
        check("data",  32'(out_data),  32'(exp_data));
        check("id",    32'(out_id),    32'(exp_id));
        check("delay", 32'(cur_delay), 32'(delay));
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (we && !mbusy && cd >= 1 && cd <= 8) delay = int'(cd);
            if (g >= 0) begin
                q.push_back('{cyc + delay, g, int'(d[g*8 +: 8])});
                ptr = (g + 1) % 4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, $urandom, 1'b0, 1'b0, 4'd0);
    endtask

    // Reset asserted between edges must clear the outputs immediately
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_delay", 32'(cur_delay), 32'd2);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_id",    32'(out_id),    32'd0);
        q.delete();
        ptr = 0; delay = 2; exp_data = 0; exp_id = 0;
        req_valid = '0; flush = 1'b0; cfg_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc++;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("init_valid", 32'(out_valid), 32'd0);
        check("init_delay", 32'(cur_delay), 32'd2);
        check("init_busy",  32'(busy),      32'd0);
        check("init_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;

        // Single word from requester 0, delay 2
        step(4'b0001, 32'h0000_0011, 1'b0, 1'b0, 4'd0);
        idle(3);

        // All requesters continuously valid: strict rotation
        for (int i = 0; i < 8; i++) step(4'b1111, $urandom, 1'b0, 1'b0, 4'd0);
        idle(3);

        // Delay 8 while idle, rejected writes while busy and out of range
        step(4'b0000, 32'h0, 1'b0, 1'b1, 4'd8);
        step(4'b0100, $urandom, 1'b0, 1'b0, 4'd0);
        step(4'b0000, 32'h0, 1'b0, 1'b1, 4'd5);
        step(4'b0000, 32'h0, 1'b0, 1'b1, 4'd5);
        idle(9);
        step(4'b0000, 32'h0, 1'b0, 1'b1, 4'd0);
        step(4'b0000, 32'h0, 1'b0, 1'b1, 4'd9);
        step(4'b0000, 32'h0, 1'b1, 1'b1, 4'd3);
        step(4'b0000, 32'h0, 1'b0, 1'b1, 4'd1);
        step(4'b0010, $urandom, 1'b0, 1'b0, 4'd0);
        idle(2);
        step(4'b0000, 32'h0, 1'b0, 1'b1, 4'd4);

        // Three words in flight, then flush with a request held
        for (int i = 0; i < 3; i++) step(4'(1 << i), $urandom, 1'b0, 1'b0, 4'd0);
        step(4'b0100, $urandom, 1'b1, 1'b0, 4'd0);
        step(4'b0100, $urandom, 1'b0, 1'b0, 4'd0);
        idle(6);

        // Async reset in the middle of a stream
        for (int i = 0; i < 3; i++) step(4'b1111, $urandom, 1'b0, 1'b0, 4'd0);
        async_reset();
        step(4'b0010, $urandom, 1'b0, 1'b0, 4'd0);
        idle(3);

        // Sparse requests: 3 alone, then 1, then 0 after the wrap
        step(4'b1000, $urandom, 1'b0, 1'b0, 4'd0);
        step(4'b0010, $urandom, 1'b0, 1'b0, 4'd0);
        step(4'b0001, $urandom, 1'b0, 1'b0, 4'd0);
        idle(3);

        // Random traffic, flushes and config writes
        for (int i = 0; i < 600; i++) begin
            logic [3:0] v;
            v = (i % 150 < 75) ? 4'($urandom) : 4'($urandom & $urandom & $urandom);
            step(v, $urandom,
                 1'($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 5) == 0),
                 4'($urandom_range(0, 10)));
        end
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
